// File: rtl/traffic_seq_ctrl_if.sv
// Register file write bus between the phase sequencer and the master register file,
// plus the serial transmitter busy flag that paces lamp-update frames.
interface traffic_seq_ctrl_if;
    logic [7:0] rf_addr;
    logic       rf_wen;
    logic [7:0] rf_data;
    logic       tx_busy;

    modport master (
        output rf_addr,
        output rf_wen,
        output rf_data,
        input  tx_busy
    );

    modport slave (
        input  rf_addr,
        input  rf_wen,
        input  rf_data,
        output tx_busy
    );
endinterface

// File: rtl/traffic_seq_ctrl.sv
// Phase sequencer: walks the NS/EW light schedule and sends one lamp-update frame per light
// through the register file write bus. Define TRAFFIC_ALL_RED_EN for all-red clearance phases.
module traffic_seq_ctrl #(
    parameter logic [15:0] GREEN_CYC  = 16'd40,
    parameter logic [15:0] YELLOW_CYC = 16'd8,
    parameter logic [15:0] ALLRED_CYC = 16'd4,
    parameter logic [1:0]  LIGHT_NS   = 2'd0,
    parameter logic [1:0]  LIGHT_EW   = 2'd1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               enable,
    traffic_seq_ctrl_if.master bus,
    output logic [2:0]         phase,
    output logic               phase_start,
    output logic               active
);

    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b001;

    localparam logic [7:0] AddrGo   = 8'h00;
    localparam logic [7:0] AddrCmd  = 8'h01;
    localparam logic [7:0] AddrDest = 8'h02;
    localparam logic [7:0] AddrLamp = 8'h03;

`ifdef TRAFFIC_ALL_RED_EN
    localparam logic [2:0] LastPhase = 3'd5;
`else
    localparam logic [2:0] LastPhase = 3'd3;
    logic unused_allred;
    assign unused_allred = ^ALLRED_CYC;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWCmd,
        StWAddr,
        StWData,
        StWGo,
        StWClr,
        StWaitTx,
        StHold
    } state_e;

    state_e      state_q;
    logic        light_ew_q;
    logic        tx_min_done_q;
    logic [15:0] hold_cnt_q;
    logic [2:0]  phase_q;
    logic        phase_start_q;
    logic        active_q;
    logic [7:0]  rf_addr_q;
    logic        rf_wen_q;
    logic [7:0]  rf_data_q;

    logic [1:0]  cur_light;
    logic [2:0]  next_phase;

    function automatic logic [2:0] lamp_of(input logic [2:0] ph, input logic ew);
        logic [2:0] lamp;
`ifdef TRAFFIC_ALL_RED_EN
        case (ph)
            3'd0:    lamp = ew ? LampR : LampG;
            3'd1:    lamp = ew ? LampR : LampY;
            3'd3:    lamp = ew ? LampG : LampR;
            3'd4:    lamp = ew ? LampY : LampR;
            default: lamp = LampR;
        endcase
`else
        case (ph)
            3'd0:    lamp = ew ? LampR : LampG;
            3'd1:    lamp = ew ? LampR : LampY;
            3'd2:    lamp = ew ? LampG : LampR;
            default: lamp = ew ? LampY : LampR;
        endcase
`endif
        return lamp;
    endfunction

    // Returns the hold length minus one; a programmed length of 0 is treated as 1.
    function automatic logic [15:0] hold_len_m1(input logic [2:0] ph);
        logic [15:0] len;
`ifdef TRAFFIC_ALL_RED_EN
        case (ph)
            3'd0, 3'd3: len = GREEN_CYC;
            3'd1, 3'd4: len = YELLOW_CYC;
            default:    len = ALLRED_CYC;
        endcase
`else
        case (ph)
            3'd0, 3'd2: len = GREEN_CYC;
            default:    len = YELLOW_CYC;
        endcase
`endif
        return (len == 16'd0) ? 16'd0 : len - 16'd1;
    endfunction

    assign cur_light  = light_ew_q ? LIGHT_EW : LIGHT_NS;
    assign next_phase = (phase_q == LastPhase) ? 3'd0 : phase_q + 3'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            light_ew_q    <= 1'b0;
            tx_min_done_q <= 1'b0;
            hold_cnt_q    <= 16'd0;
            phase_q       <= 3'd0;
            phase_start_q <= 1'b0;
            active_q      <= 1'b0;
            rf_addr_q     <= 8'h00;
            rf_wen_q      <= 1'b0;
            rf_data_q     <= 8'h00;
        end else begin
            // Outputs are registered with the state they belong to; idle values by default.
            rf_addr_q     <= 8'h00;
            rf_wen_q      <= 1'b0;
            rf_data_q     <= 8'h00;
            phase_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q    <= StWCmd;
                        light_ew_q <= 1'b0;
                        active_q   <= 1'b1;
                        rf_wen_q   <= 1'b1;
                        rf_addr_q  <= AddrCmd;
                        rf_data_q  <= 8'h01;
                    end
                end
                StWCmd: begin
                    state_q   <= StWAddr;
                    rf_wen_q  <= 1'b1;
                    rf_addr_q <= AddrDest;
                    rf_data_q <= {6'b0, cur_light};
                end
                StWAddr: begin
                    state_q   <= StWData;
                    rf_wen_q  <= 1'b1;
                    rf_addr_q <= AddrLamp;
                    rf_data_q <= {5'b0, lamp_of(phase_q, light_ew_q)};
                end
                StWData: begin
                    state_q   <= StWGo;
                    rf_wen_q  <= 1'b1;
                    rf_addr_q <= AddrGo;
                    rf_data_q <= 8'h01;
                end
                StWGo: begin
                    // Clearing the go register re-arms the transmitter start edge detector.
                    state_q   <= StWClr;
                    rf_wen_q  <= 1'b1;
                    rf_addr_q <= AddrGo;
                    rf_data_q <= 8'h00;
                end
                StWClr: begin
                    state_q       <= StWaitTx;
                    tx_min_done_q <= 1'b0;
                end
                StWaitTx: begin
                    // Two-cycle floor covers the transmitter's latency in raising tx_busy.
                    if (tx_min_done_q && !bus.tx_busy) begin
                        if (!light_ew_q) begin
                            state_q    <= StWCmd;
                            light_ew_q <= 1'b1;
                            rf_wen_q   <= 1'b1;
                            rf_addr_q  <= AddrCmd;
                            rf_data_q  <= 8'h01;
                        end else begin
                            state_q       <= StHold;
                            hold_cnt_q    <= hold_len_m1(phase_q);
                            phase_start_q <= 1'b1;
                        end
                    end else begin
                        tx_min_done_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == 16'd0) begin
                        phase_q <= next_phase;
                        if (enable) begin
                            state_q    <= StWCmd;
                            light_ew_q <= 1'b0;
                            rf_wen_q   <= 1'b1;
                            rf_addr_q  <= AddrCmd;
                            rf_data_q  <= 8'h01;
                        end else begin
                            state_q  <= StIdle;
                            active_q <= 1'b0;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_wen  = rf_wen_q;
    assign bus.rf_data = rf_data_q;
    assign phase       = phase_q;
    assign phase_start = phase_start_q;
    assign active      = active_q;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Self-checking bench for traffic_seq_ctrl: randomized enable/tx_busy against a schedule-table
// model. Honours TRAFFIC_ALL_RED_EN when the build defines it.
module tb_traffic_seq_ctrl;

    localparam logic [15:0] GREEN  = 16'd40;
    localparam logic [15:0] YEL    = 16'd8;
    localparam logic [15:0] ALLRED = 16'd4;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

`ifdef TRAFFIC_ALL_RED_EN
    localparam int NPH = 6;
    localparam logic [17:0] NS_SCHED = {LR, LR, LR, LR, LY, LG};
    localparam logic [17:0] EW_SCHED = {LR, LY, LG, LR, LR, LR};
`else
    localparam int NPH = 4;
    localparam logic [11:0] NS_SCHED = {LR, LR, LY, LG};
    localparam logic [11:0] EW_SCHED = {LY, LG, LR, LR};
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] phase;
    logic       phase_start;
    logic       active;

    int checks = 0;
    int errors = 0;
    int m_phase = 0;

    traffic_seq_ctrl_if bus ();

    traffic_seq_ctrl #(
        .GREEN_CYC  (GREEN),
        .YELLOW_CYC (YEL),
        .ALLRED_CYC (ALLRED),
        .LIGHT_NS   (2'd0),
        .LIGHT_EW   (2'd1)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .bus         (bus),
        .phase       (phase),
        .phase_start (phase_start),
        .active      (active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] m_lamp(input int ph, input int ew);
        return ew != 0 ? EW_SCHED[ph*3 +: 3] : NS_SCHED[ph*3 +: 3];
    endfunction

    function automatic int m_dur(input int ph);
        if (m_lamp(ph, 0) == LG || m_lamp(ph, 1) == LG) return int'(GREEN);
        if (m_lamp(ph, 0) == LY || m_lamp(ph, 1) == LY) return int'(YEL);
        return int'(ALLRED);
    endfunction

    // Entered at the W_CMD cycle of a phase; runs both frames and the hold, advancing the model.
    task automatic drive_phase(input int bmin, input int bmax, input bit en_end);
        int b;
        int wlen;
        int d;
        logic [7:0] ea;
        logic [7:0] ed;
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 5; k++) begin
                enable = 1'($urandom_range(1, 0));
                bus.tx_busy = 1'b0;
                case (k)
                    0: begin ea = 8'h01; ed = 8'h01; end
                    1: begin ea = 8'h02; ed = 8'(l); end
                    2: begin ea = 8'h03; ed = {5'b0, m_lamp(m_phase, l)}; end
                    3: begin ea = 8'h00; ed = 8'h01; end
                    default: begin ea = 8'h00; ed = 8'h00; end
                endcase
                checks++;
                if (bus.rf_wen !== 1'b1 || bus.rf_addr !== ea || bus.rf_data !== ed) begin
                    errors++;
                    $display("FAIL frame_write ph=%0d light=%0d k=%0d: got wen=%b %h/%h want wen=1 %h/%h",
                             m_phase, l, k, bus.rf_wen, bus.rf_addr, bus.rf_data, ea, ed);
                end
                checks++;
                if (phase !== 3'(m_phase) || active !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_state ph=%0d: got phase=%0d active=%b want phase=%0d active=1",
                             m_phase, phase, active, m_phase);
                end
                tick();
            end
            b = int'($urandom_range(bmax, bmin));
            wlen = (b > 1 ? b : 1) + 1;
            for (int j = 0; j < wlen; j++) begin
                bus.tx_busy = (j < b);
                enable = 1'($urandom_range(1, 0));
                checks++;
                if (bus.rf_wen !== 1'b0 || bus.rf_addr !== 8'h00 || bus.rf_data !== 8'h00
                    || phase_start !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_tx ph=%0d j=%0d busy=%0d: got wen=%b %h/%h ps=%b want 0 00/00 0",
                             m_phase, j, b, bus.rf_wen, bus.rf_addr, bus.rf_data, phase_start);
                end
                tick();
            end
            bus.tx_busy = 1'b0;
        end
        d = m_dur(m_phase);
        for (int j = 0; j < d; j++) begin
            enable = (j == d - 1) ? en_end : 1'($urandom_range(1, 0));
            checks++;
            if (phase_start !== (j == 0) || phase !== 3'(m_phase) || bus.rf_wen !== 1'b0
                || active !== 1'b1) begin
                errors++;
                $display("FAIL hold ph=%0d j=%0d: got ps=%b phase=%0d wen=%b act=%b want ps=%b phase=%0d wen=0 act=1",
                         m_phase, j, phase_start, phase, bus.rf_wen, active, (j == 0), m_phase);
            end
            tick();
        end
        m_phase = (m_phase + 1) % NPH;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        enable = 1'b0;
        bus.tx_busy = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.rf_addr !== 8'h00 || bus.rf_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got wen=%b %h/%h want 0 00/00",
                     bus.rf_wen, bus.rf_addr, bus.rf_data);
        end
        checks++;
        if (phase !== 3'd0 || phase_start !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got phase=%0d ps=%b act=%b want 0 0 0",
                     phase, phase_start, active);
        end
    endtask

    task automatic test_first_phase();
        n_rst = 1'b1;
        m_phase = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.rf_wen !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: got wen=%b act=%b want 0 0", bus.rf_wen, active);
            end
        end
        enable = 1'b1;
        tick();
        drive_phase(0, 0, 1'b1);
    endtask

    task automatic test_schedule_wrap();
        for (int i = 0; i < NPH + 1; i++) drive_phase(0, 4, 1'b1);
        checks++;
        if (phase !== 3'(m_phase) || bus.rf_wen !== 1'b1) begin
            errors++;
            $display("FAIL wrap_next: got phase=%0d wen=%b want phase=%0d wen=1",
                     phase, bus.rf_wen, m_phase);
        end
    endtask

    task automatic test_busy();
        drive_phase(10, 14, 1'b1);
        drive_phase(10, 14, 1'b1);
    endtask

    task automatic test_enable_drop();
        while (m_phase != 1) drive_phase(0, 3, 1'b1);
        drive_phase(0, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            enable = 1'b0;
            checks++;
            if (active !== 1'b0 || phase !== 3'd2 || bus.rf_wen !== 1'b0) begin
                errors++;
                $display("FAIL enable_drop_idle i=%0d: got act=%b phase=%0d wen=%b want 0 2 0",
                         i, active, phase, bus.rf_wen);
            end
            tick();
        end
        enable = 1'b1;
        tick();
        drive_phase(0, 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_addr !== 8'h03) begin
            errors++;
            $display("FAIL pre_reset_wdata: got wen=%b addr=%h want 1 03", bus.rf_wen, bus.rf_addr);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.rf_addr !== 8'h00 || bus.rf_data !== 8'h00
            || phase !== 3'd0 || active !== 1'b0 || phase_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got wen=%b %h/%h phase=%0d act=%b ps=%b want all 0",
                     bus.rf_wen, bus.rf_addr, bus.rf_data, phase, active, phase_start);
        end
        enable = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        m_phase = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.rf_wen !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got wen=%b act=%b want 0 0", bus.rf_wen, active);
            end
        end
        enable = 1'b1;
        tick();
        drive_phase(0, 3, 1'b0);
        checks++;
        if (active !== 1'b0 || phase !== 3'd1) begin
            errors++;
            $display("FAIL restart_end: got act=%b phase=%0d want 0 1", active, phase);
        end
    endtask

    initial begin
        bus.tx_busy = 1'b0;
        test_reset();
        test_first_phase();
        test_schedule_wrap();
        test_busy();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
